// File: rtl/rca_ft_selftest_ctrl.sv
// Self-test and reconfiguration sequencer for the fault-tolerant 4-bit ripple-carry adder.
// Sweeps all {c1,b,a} patterns, bypasses the first faulty slice onto the spare, re-verifies, then runs.
module rca_ft_selftest_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] op_a,
  input  logic [3:0] op_b,
  input  logic       op_cin,
  input  logic       op_valid,
  output logic [3:0] res_sum,
  output logic       res_cout,
  output logic       res_valid,
  output logic       busy,
  output logic       done,
  output logic       fail,
  output logic       fault_valid,
  output logic [1:0] fault_slice,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic       c1,
  output logic       test,
  output logic [5:0] is_sel,
  output logic [4:0] cs_sel,
  output logic [3:0] ss_sel,
  output logic [4:0] A,
  output logic [4:0] B,
  input  logic [3:0] s,
  input  logic       cout
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SWEEP, ST_RECONF, ST_VERIFY, ST_DONE, ST_FAIL
  } state_t;

  state_t     state, state_nxt;
  logic [8:0] cnt;
  logic       pend;
  logic       drain;
  logic [4:0] exp_q;
  logic [1:0] k_q;
  logic       run_pend;
  logic [4:0] diff;
  logic       mism;
  logic [1:0] k_calc;
  logic       scanning;
  logic       start_acc;
  logic [5:0] therm;

  assign scanning  = (state == ST_SWEEP) || (state == ST_VERIFY);
  assign start_acc = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_FAIL));
  assign diff      = {cout, s} ^ exp_q;
  assign mism      = pend && (diff != 5'd0);

  // Lowest mismatching sum bit; a carry-out-only mismatch blames the top slice.
  always_comb begin
    k_calc = 2'd3;
    if (diff[0])      k_calc = 2'd0;
    else if (diff[1]) k_calc = 2'd1;
    else if (diff[2]) k_calc = 2'd2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE, ST_FAIL: if (start) state_nxt = ST_SWEEP;
      ST_SWEEP: begin
        if (mism)       state_nxt = ST_RECONF;
        else if (drain) state_nxt = ST_DONE;
      end
      ST_RECONF: state_nxt = ST_VERIFY;
      ST_VERIFY: begin
        if (mism)       state_nxt = ST_FAIL;
        else if (drain) state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      pend        <= 1'b0;
      drain       <= 1'b0;
      exp_q       <= '0;
      k_q         <= '0;
      run_pend    <= 1'b0;
      fault_valid <= 1'b0;
      fault_slice <= '0;
      a           <= '0;
      b           <= '0;
      c1          <= 1'b0;
    end else if (start_acc) begin
      cnt         <= '0;
      pend        <= 1'b0;
      drain       <= 1'b0;
      run_pend    <= 1'b0;
      fault_valid <= 1'b0;
    end else if (scanning) begin
      if (mism || drain) begin
        // Compare result decides the exit; no further pattern is launched.
        pend  <= 1'b0;
        drain <= 1'b0;
        if (state == ST_SWEEP) k_q <= k_calc;
      end else begin
        a     <= cnt[3:0];
        b     <= cnt[7:4];
        c1    <= cnt[8];
        exp_q <= {1'b0, cnt[3:0]} + {1'b0, cnt[7:4]} + {4'b0, cnt[8]};
        pend  <= 1'b1;
        cnt   <= cnt + 9'd1;
        if (cnt == 9'd511) drain <= 1'b1;
      end
    end else if (state == ST_RECONF) begin
      fault_valid <= 1'b1;
      fault_slice <= k_q;
      cnt         <= '0;
      pend        <= 1'b0;
      drain       <= 1'b0;
    end else if (state == ST_DONE) begin
      run_pend <= op_valid;
      if (op_valid) begin
        a  <= op_a;
        b  <= op_b;
        c1 <= op_cin;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_sum   <= '0;
      res_cout  <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      res_valid <= run_pend;
      if (run_pend) begin
        res_sum  <= s;
        res_cout <= cout;
      end
    end
  end

  function automatic logic [4:0] spread(input logic [3:0] v, input logic [1:0] k);
    case (k)
      2'd0:    spread = {v, 1'b0};
      2'd1:    spread = {v[3:1], 1'b0, v[0]};
      2'd2:    spread = {v[3:2], 1'b0, v[1:0]};
      default: spread = {v[3], 1'b0, v[2:0]};
    endcase
  endfunction

  assign therm  = fault_valid ? (6'b111111 << fault_slice) : 6'b0;
  assign is_sel = therm;
  assign cs_sel = therm[4:0];
  assign ss_sel = therm[3:0];
  assign A      = fault_valid ? spread(a, fault_slice) : {1'b0, a};
  assign B      = fault_valid ? spread(b, fault_slice) : {1'b0, b};

  assign busy = (state == ST_SWEEP) || (state == ST_RECONF) || (state == ST_VERIFY);
  assign done = (state == ST_DONE);
  assign fail = (state == ST_FAIL);
  assign test = scanning;

endmodule

// File: doc/rca_ft_selftest_ctrl.md
# rca_ft_selftest_ctrl

Sequential self-test and reconfiguration controller that sits directly upstream of the fault-tolerant 4-bit ripple-carry adder (`rca_ft`). It drives every adder input: operands, carry-in, `test`, the input/carry/sum steering selects and the 5-bit spare-path operands. It consumes the adder's `s`/`cout`. On `start` it sweeps all 512 operand patterns, localises the first faulty bit slice, steers around it onto the spare slice, then re-verifies. Afterwards it passes system operands through to the adder.

## Interface
- `NPAT`, 512: patterns per sweep; fixed as {c1,b,a} = 9-bit counter.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; sampled only in IDLE/DONE/FAIL.
- `op_a`, `op_b`  in  4  system operands (RUN only).
- `op_cin`  in  1  system carry-in.
- `op_valid`  in  1  system operand strobe.
- `res_sum`  out  4  registered adder sum.
- `res_cout`  out  1  registered adder carry-out.
- `res_valid`  out  1  high one cycle after an accepted `op_valid`.
- `busy`  out  1  high in SWEEP/RECONF/VERIFY.
- `done`  out  1  level; high in DONE (adder usable).
- `fail`  out  1  level; high in FAIL (uncorrectable).
- `fault_valid`  out  1  a slice has been bypassed.
- `fault_slice`  out  2  index of bypassed slice.
- `a`, `b`  out  4  adder operands. `c1`  out  1  adder carry-in.
- `test`  out  1  adder test-mode enable.
- `is_sel`  out  6  → is0..is5. `cs_sel`  out  5  → CS0..CS4. `ss_sel`  out  4  → SS0..SS3.
- `A`, `B`  out  5  spare-path operands.
- `s`  in  4  adder sum. `cout`  in  1  adder carry-out.

## Operation
- States: IDLE, SWEEP, RECONF, VERIFY, DONE, FAIL.
- Reset: state IDLE; all outputs 0; pattern counter 0; `fault_slice` 0.
- IDLE/DONE/FAIL + `start`: clear counter, `fault_valid`, `fail` and selects, then enter SWEEP. `start` in any other state is ignored.
- SWEEP/VERIFY:
  - `test`=1.
  - Each cycle register {c1,b,a}=cnt and expected = a+b+c1 (5 bits). Increment cnt.
  - One cycle later compare {cout,s} against the registered expected value.
- Mismatch in SWEEP: faulty slice k = lowest mismatching `s` bit. If only `cout` mismatches, k=3. Latch k and go to RECONF, aborting the rest of the sweep.
- Mismatch in VERIFY → FAIL.
- SWEEP completes with no mismatch → DONE with `fault_valid`=0. VERIFY completes with no mismatch → DONE.
- RECONF lasts one cycle:
  - Sets `fault_valid`=1, `fault_slice`=k.
  - Thermometer selects: bit j of `is_sel`, `cs_sel` and `ss_sel` is 1 iff j ≥ k.
  - Clears cnt, then VERIFY.
- Spare operands, driven whenever `fault_valid`=1:
  - A[j]=a[j] for j<k; A[k]=0; A[j]=a[j-1] for j>k. B is built the same way from b.
  - When `fault_valid`=0, A={1'b0,a} and B={1'b0,b}.
- DONE (RUN):
  - `test`=0.
  - On `op_valid`, drive a/b/c1 from `op_*`, and spare operands per the rule above.
  - Next cycle register s/cout into `res_*` and pulse `res_valid`.
  - `op_valid` outside DONE is ignored. Selects hold.
- FAIL: `fail`=1, `test`=0. Operands are not accepted. Only `start` or reset exits.

## Timing
- Counter width 9 bits. The cnt=511→0 wrap ends the sweep. No overflow state.
- Compare pipeline depth 1.
- Clean SWEEP: 512 drive cycles + 1 drain cycle. `busy` high 513 cycles. `done` rises on cycle 514 after the `start` edge.
- With a fault: SWEEP to the first mismatch + 1 RECONF cycle + 513 VERIFY cycles.
- `busy`, `done` and `fail` are mutually exclusive. `done` and `fail` stay asserted until `start` or reset.
- Mismatch on the same cycle cnt wraps: the mismatch wins (RECONF or FAIL).
- `rst_n` low mid-sweep: everything returns immediately (asynchronously) to reset values. Fault information is lost.
- RUN latency: `op_valid` at edge n → `res_valid` at edge n+1. Back-to-back ops are allowed every cycle.

## Test plan
- Fault-free adder model, `start` pulse → `busy` for 513 cycles, then `done`=1, `fault_valid`=0, all selects 0; op 9+11+0 → `res_sum`=4, `res_cout`=1, one cycle later.
- Slice 1 sum stuck-at-0 in the model → `fault_slice`=1, `is_sel`=6'b111110, `cs_sel`=5'b11110, `ss_sel`=4'b1110; VERIFY passes; `done`=1; a=4'b1001 drives A=5'b10001.
- Carry-out-only fault → `fault_slice`=3, `ss_sel`=4'b1000, then `done`.
- Fault persisting after reconfiguration (model ignores the selects) → FAIL after RECONF + first VERIFY mismatch; `fail`=1, `done`=0; `op_valid` yields no `res_valid`.
- `rst_n` asserted at SWEEP cycle 200 → all outputs 0 immediately. A new `start` after release completes a full 513-cycle sweep.
- `start` pulsed during SWEEP → ignored, sweep length unchanged. `start` in DONE → re-test clears `fault_valid`.
